// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcodes, bus select codes and multiplier state type for risc_datapath_param
package risc_pkg;

    localparam int OPC_NOP = 0;
    localparam int OPC_ADD = 1;
    localparam int OPC_SUB = 2;
    localparam int OPC_AND = 3;
    localparam int OPC_NOT = 4;
    localparam int OPC_RD  = 5;
    localparam int OPC_WR  = 6;
    localparam int OPC_BR  = 7;
    localparam int OPC_BRZ = 8;
    localparam int OPC_MUL = 9;

    localparam int SEL2_ALU    = 0;
    localparam int SEL2_BUS1   = 1;
    localparam int SEL2_MEM    = 2;
    localparam int SEL2_MUL_LO = 3;
    localparam int SEL2_MUL_HI = 4;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/risc_datapath_param_seq_multiplier.sv
// rtl/risc_datapath_param_seq_multiplier.sv - unsigned shift-add multiplier, one step per cycle
module seq_multiplier
    import risc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mdflag_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             mdflag_q;
    logic [WIDTH:0]   step_sum;

    // Partial-product add for the current multiplier bit; carry lands in bit WIDTH
    always_comb begin
        step_sum = {1'b0, hi_q};
        if (b_q[0]) begin
            step_sum = {1'b0, hi_q} + {1'b0, a_q};
        end
    end

    // Control FSM with operand/product registers; the product shifts right as bits are consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mdflag_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        hi_q     <= '0;
                        lo_q     <= '0;
                        cnt_q    <= '0;
                        mdflag_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    hi_q  <= step_sum[WIDTH:1];
                    lo_q  <= {step_sum[0], lo_q[WIDTH-1:1]};
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        mdflag_q <= 1'b1;
                        state_q  <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state_q <= MUL_IDLE;
                end
                default: begin
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

    assign lo_o     = lo_q;
    assign hi_o     = hi_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign mdflag_o = mdflag_q;

endmodule

// File: rtl/risc_datapath_param.sv
// rtl/risc_datapath_param.sv - RISC-SPM datapath with register file, ALU, flags and multiplier; RISC_SAT_ARITH_EN enables saturating ADD/SUB
module risc_datapath_param
    import risc_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int NUM_REGS  = 4,
    parameter int SEL1_SIZE = $clog2(NUM_REGS + 1),
    parameter int SEL2_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] mem_word,
    input  logic [NUM_REGS-1:0]  load_reg,
    input  logic                 load_pc,
    input  logic                 inc_pc,
    input  logic                 load_ir,
    input  logic                 load_add_r,
    input  logic                 load_reg_y,
    input  logic                 load_flags,
    input  logic [SEL1_SIZE-1:0] sel_bus_1,
    input  logic [SEL2_SIZE-1:0] sel_bus_2,
    input  logic                 mul_start,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] bus_1,
    output logic                 zflag,
    output logic                 nflag,
    output logic                 ovflag,
    output logic                 mdflag,
    output logic                 mul_busy,
    output logic                 mul_done
);

    localparam int MSB = WORD_SIZE - 1;

    logic [WORD_SIZE-1:0] r_q [NUM_REGS];
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] ir_q;
    logic [WORD_SIZE-1:0] add_r_q;
    logic [WORD_SIZE-1:0] y_q;
    logic                 z_q;
    logic                 n_q;
    logic                 v_q;

    logic [WORD_SIZE-1:0] bus_2;
    logic [WORD_SIZE-1:0] mul_lo;
    logic [WORD_SIZE-1:0] mul_hi;
    logic [OP_SIZE-1:0]   opcode;
    logic [WORD_SIZE-1:0] sum_w;
    logic [WORD_SIZE-1:0] diff_w;
    logic [WORD_SIZE-1:0] alu_raw;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 alu_v;

    assign opcode = ir_q[WORD_SIZE-1 -: OP_SIZE];

    // Bus_1: general registers, then PC, everything else reads as zero
    always_comb begin
        bus_1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_bus_1 == SEL1_SIZE'(i)) begin
                bus_1 = r_q[i];
            end
        end
        if (sel_bus_1 == SEL1_SIZE'(NUM_REGS)) begin
            bus_1 = pc_q;
        end
    end

    // Bus_2: write-back source for registers, PC, IR, address and Y
    always_comb begin
        bus_2 = '0;
        case (sel_bus_2)
            SEL2_SIZE'(SEL2_ALU):    bus_2 = alu_out;
            SEL2_SIZE'(SEL2_BUS1):   bus_2 = bus_1;
            SEL2_SIZE'(SEL2_MEM):    bus_2 = mem_word;
            SEL2_SIZE'(SEL2_MUL_LO): bus_2 = mul_lo;
            SEL2_SIZE'(SEL2_MUL_HI): bus_2 = mul_hi;
            default:                 bus_2 = '0;
        endcase
    end

    // ALU on A=Bus_1, B=Y with signed overflow detection for ADD and SUB
    always_comb begin
        sum_w   = bus_1 + y_q;
        diff_w  = bus_1 - y_q;
        alu_raw = bus_1;
        alu_v   = 1'b0;
        case (opcode)
            OP_SIZE'(OPC_ADD): begin
                alu_raw = sum_w;
                alu_v   = (bus_1[MSB] == y_q[MSB]) && (sum_w[MSB] != bus_1[MSB]);
            end
            OP_SIZE'(OPC_SUB): begin
                alu_raw = diff_w;
                alu_v   = (bus_1[MSB] != y_q[MSB]) && (diff_w[MSB] != bus_1[MSB]);
            end
            OP_SIZE'(OPC_AND): alu_raw = bus_1 & y_q;
            OP_SIZE'(OPC_NOT): alu_raw = ~bus_1;
            default:           alu_raw = bus_1;
        endcase
    end

    // Overflow direction follows the sign of A for both ADD and SUB
    always_comb begin
`ifdef RISC_SAT_ARITH_EN
        alu_out = alu_raw;
        if (alu_v) begin
            alu_out = bus_1[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
`else
        alu_out = alu_raw;
`endif
    end

    // General register file; several enables may load the same Bus_2 value together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load_reg[i]) begin
                    r_q[i] <= bus_2;
                end
            end
        end
    end

    // Program counter; an explicit load wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else if (load_pc) begin
            pc_q <= bus_2;
        end else if (inc_pc) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    // IR, address and Y operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q    <= '0;
            add_r_q <= '0;
            y_q     <= '0;
        end else begin
            if (load_ir) begin
                ir_q <= bus_2;
            end
            if (load_add_r) begin
                add_r_q <= bus_2;
            end
            if (load_reg_y) begin
                y_q <= bus_2;
            end
        end
    end

    // Condition flags captured from the ALU only on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (load_flags) begin
            z_q <= (alu_out == '0);
            n_q <= alu_out[MSB];
            v_q <= alu_v;
        end
    end

    seq_multiplier #(
        .WIDTH (WORD_SIZE)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst),
        .start_i  (mul_start),
        .a_i      (bus_1),
        .b_i      (y_q),
        .lo_o     (mul_lo),
        .hi_o     (mul_hi),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .mdflag_o (mdflag)
    );

    assign instruction = ir_q;
    assign address     = add_r_q;
    assign zflag       = z_q;
    assign nflag       = n_q;
    assign ovflag      = v_q;

endmodule
